// File: rtl/dsi_link_sequencer_if.sv
// Control/status bundle between the DSI link sequencer and the PHY / packet assembler.
interface dsi_link_sequencer_if;
    logic       start_req;
    logic       stop_req;
    logic       clock_ready;
    logic       lines_ready;
    logic       lines_active;
    logic       clock_enable;
    logic       lines_enable;
    logic       streaming_enable;
    logic       link_up;
    logic       busy;
    logic       error;
    logic [2:0] seq_state;

    modport master (
        output start_req, stop_req, clock_ready, lines_ready, lines_active,
        input  clock_enable, lines_enable, streaming_enable, link_up, busy, error, seq_state
    );

    modport slave (
        input  start_req, stop_req, clock_ready, lines_ready, lines_active,
        output clock_enable, lines_enable, streaming_enable, link_up, busy, error, seq_state
    );
endinterface

// File: rtl/dsi_link_sequencer.sv
// DSI link power-up/down sequencer: clock lane, data lanes, settle, stream, orderly shutdown.
// Optional wait-state timeout watchdog enabled by defining DSI_SEQ_TIMEOUT_EN.
module dsi_link_sequencer #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    dsi_link_sequencer_if.slave     lnk
);

    localparam int unsigned SETTLE_W = 8;
    localparam int unsigned WAIT_W   = 16;

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
        $error("dsi_link_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CLK_UP     = 3'd1,
        S_LANES_UP   = 3'd2,
        S_SETTLE     = 3'd3,
        S_STREAM     = 3'd4,
        S_DRAIN      = 3'd5,
        S_LANES_DOWN = 3'd6,
        S_CLK_DOWN   = 3'd7
    } state_t;

    state_t              state, state_nxt;
    logic [SETTLE_W-1:0] settle_cnt, settle_cnt_nxt;
    logic                error_nxt;
    logic                timeout;

`ifdef DSI_SEQ_TIMEOUT_EN
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_state;

    assign wait_state = (state == S_CLK_UP) || (state == S_LANES_UP) || (state == S_DRAIN) ||
                        (state == S_LANES_DOWN) || (state == S_CLK_DOWN);
    // Fires on the last permitted cycle so no state lingers beyond TIMEOUT_CYCLES.
    assign timeout = wait_state && (wait_cnt >= WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wait_cnt <= '0;
        end else if ((state_nxt != state) || !wait_state) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(TIMEOUT_CYCLES)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State, settle counter and registered Moore outputs decoded from the next state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state                <= S_IDLE;
            settle_cnt           <= '0;
            lnk.error            <= 1'b0;
            lnk.clock_enable     <= 1'b0;
            lnk.lines_enable     <= 1'b0;
            lnk.streaming_enable <= 1'b0;
            lnk.link_up          <= 1'b0;
            lnk.busy             <= 1'b0;
        end else begin
            state                <= state_nxt;
            settle_cnt           <= settle_cnt_nxt;
            lnk.error            <= error_nxt;
            lnk.clock_enable     <= (state_nxt != S_IDLE) && (state_nxt != S_CLK_DOWN);
            lnk.lines_enable     <= (state_nxt == S_LANES_UP) || (state_nxt == S_SETTLE) ||
                                    (state_nxt == S_STREAM) || (state_nxt == S_DRAIN);
            lnk.streaming_enable <= (state_nxt == S_STREAM);
            lnk.link_up          <= (state_nxt == S_STREAM);
            lnk.busy             <= (state_nxt != S_IDLE) && (state_nxt != S_STREAM);
        end
    end

    assign lnk.seq_state = state;

    // Next-state logic; stop_req has priority over start_req and over normal progress.
    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        error_nxt      = lnk.error;

        unique case (state)
            S_IDLE: begin
                if (lnk.start_req && !lnk.stop_req) begin
                    state_nxt = S_CLK_UP;
                    error_nxt = 1'b0;
                end
            end
            S_CLK_UP: begin
                if (lnk.stop_req)         state_nxt = S_LANES_DOWN;
                else if (lnk.clock_ready) state_nxt = S_LANES_UP;
                else if (timeout)         state_nxt = S_LANES_DOWN;
            end
            S_LANES_UP: begin
                if (lnk.stop_req) begin
                    state_nxt = S_LANES_DOWN;
                end else if (lnk.lines_ready) begin
                    state_nxt      = S_SETTLE;
                    settle_cnt_nxt = SETTLE_W'(SETTLE_CYCLES - 1);
                end else if (timeout) begin
                    state_nxt = S_LANES_DOWN;
                end
            end
            S_SETTLE: begin
                if (lnk.stop_req)               state_nxt = S_LANES_DOWN;
                else if (settle_cnt == '0)      state_nxt = S_STREAM;
                else                            settle_cnt_nxt = settle_cnt - SETTLE_W'(1);
            end
            S_STREAM: begin
                if (!lnk.clock_ready || !lnk.lines_ready) begin
                    state_nxt = S_DRAIN;
                    error_nxt = 1'b1;
                end else if (lnk.stop_req) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!lnk.lines_active || timeout) state_nxt = S_LANES_DOWN;
            end
            S_LANES_DOWN: begin
                if (!lnk.lines_ready || timeout) state_nxt = S_CLK_DOWN;
            end
            S_CLK_DOWN: begin
                if (!lnk.clock_ready || timeout) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // A timeout is always recorded, even when a normal exit wins the same cycle.
        if (timeout) error_nxt = 1'b1;
    end

endmodule

// File: tb/tb_dsi_link_sequencer.sv
// Directed, table-driven bench for dsi_link_sequencer (default parameters).
// Timeout cases follow DSI_SEQ_TIMEOUT_EN when the bench is built with that macro.
module tb_dsi_link_sequencer;

    localparam logic [2:0] IDLE = 3'd0, CLK_UP = 3'd1, LANES_UP = 3'd2, SETTLE = 3'd3,
                           STREAM = 3'd4, DRAIN = 3'd5, LANES_DOWN = 3'd6, CLK_DOWN = 3'd7;

    typedef struct {
        logic       start;
        logic       stop;
        logic       cr;
        logic       lr;
        logic       la;
        int         n;
        logic [2:0] exp_st;
        logic       exp_err;
    } vec_t;

    logic sys_clk;
    logic sys_rst_n;
    int   checks;
    int   errors;
    vec_t vecs[$];

    dsi_link_sequencer_if lnk ();

    dsi_link_sequencer dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .lnk       (lnk.slave)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic vec_t mk(logic s, logic p, logic cr, logic lr, logic la, int n,
                                logic [2:0] st, logic err);
        vec_t v;
        v.start = s; v.stop = p; v.cr = cr; v.lr = lr; v.la = la; v.n = n;
        v.exp_st = st; v.exp_err = err;
        return v;
    endfunction

    // Expected output vector {clock_en, lines_en, stream_en, link_up, busy, error} for a state.
    function automatic logic [5:0] exp_outs(logic [2:0] st, logic err);
        logic ce, le, se, bz;
        ce = (st >= 3'd1) && (st <= 3'd6);
        le = (st >= 3'd2) && (st <= 3'd5);
        se = (st == STREAM);
        bz = (st != IDLE) && (st != STREAM);
        return {ce, le, se, se, bz, err};
    endfunction

    task automatic check(string name, logic [2:0] exp_st, logic exp_err);
        logic [5:0] act, exp;
        act = {lnk.clock_enable, lnk.lines_enable, lnk.streaming_enable,
               lnk.link_up, lnk.busy, lnk.error};
        exp = exp_outs(exp_st, exp_err);
        checks++;
        if (lnk.seq_state !== exp_st) begin
            errors++;
            $display("FAIL %s: seq_state got %0d want %0d", name, lnk.seq_state, exp_st);
        end
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: outputs(ce,le,se,up,busy,err) got %b want %b", name, act, exp);
        end
    endtask

    task automatic drive(logic s, logic p, logic cr, logic lr, logic la);
        lnk.start_req    = s;
        lnk.stop_req     = p;
        lnk.clock_ready  = cr;
        lnk.lines_ready  = lr;
        lnk.lines_active = la;
    endtask

    task automatic apply(string name, vec_t v);
        drive(v.start, v.stop, v.cr, v.lr, v.la);
        repeat (v.n) @(posedge sys_clk);
        #1;
        check(name, v.exp_st, v.exp_err);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(0, 0, 0, 0, 0);
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset", IDLE, 0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        // Collision in IDLE, then full bring-up and orderly shutdown.
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, IDLE, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, CLK_UP, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4, CLK_UP, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, LANES_UP, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4, LANES_UP, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, SETTLE, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 15, SETTLE, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, STREAM, 0));
        vecs.push_back(mk(1, 0, 1, 1, 1, 1, STREAM, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 4, STREAM, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, DRAIN, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 9, DRAIN, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, LANES_DOWN, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 3, LANES_DOWN, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, CLK_DOWN, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, IDLE, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, IDLE, 0));
        // Link loss in STREAM, sticky error, cleared by the next start.
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, CLK_UP, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, LANES_UP, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, SETTLE, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 16, STREAM, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, DRAIN, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, LANES_DOWN, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, CLK_DOWN, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, IDLE, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, CLK_UP, 0));
        // Stop during SETTLE and during CLK_UP aborts straight to LANES_DOWN.
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, LANES_UP, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, SETTLE, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 3, SETTLE, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, LANES_DOWN, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, CLK_DOWN, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, IDLE, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, CLK_UP, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, LANES_DOWN, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, CLK_DOWN, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, IDLE, 0));
`ifdef DSI_SEQ_TIMEOUT_EN
        // Watchdog: 1023 cycles in CLK_UP, then forced power-down.
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, CLK_UP, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1022, CLK_UP, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, LANES_DOWN, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, CLK_DOWN, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, IDLE, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, CLK_UP, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, LANES_DOWN, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, CLK_DOWN, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, IDLE, 0));
`endif

        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

`ifndef DSI_SEQ_TIMEOUT_EN
        // Without the watchdog CLK_UP waits forever and never flags an error.
        begin
            int bad;
            bad = 0;
            drive(1, 0, 0, 0, 0);
            @(posedge sys_clk);
            #1;
            drive(0, 0, 0, 0, 0);
            for (int c = 0; c < 5000; c++) begin
                if (lnk.seq_state !== CLK_UP || lnk.error !== 1'b0) bad++;
                @(posedge sys_clk);
                #1;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL no_timeout: cycles off CLK_UP/error got %0d want 0", bad);
            end
            check("no_timeout_end", CLK_UP, 0);
            drive(0, 1, 0, 0, 0);
            @(posedge sys_clk);
            #1;
            drive(0, 0, 0, 0, 0);
            repeat (2) @(posedge sys_clk);
            #1;
            check("no_timeout_idle", IDLE, 0);
        end
`endif

        // Asynchronous reset while streaming drops every enable before any clock edge.
        apply("rst_a", mk(1, 0, 0, 0, 0, 1, CLK_UP, 0));
        apply("rst_b", mk(0, 0, 1, 1, 0, 2, SETTLE, 0));
        apply("rst_c", mk(0, 0, 1, 1, 0, 16, STREAM, 0));
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("rst_stream", IDLE, 0);
        drive(0, 0, 0, 0, 0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        check("rst_release", IDLE, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
